// File: rtl/lsb_mem_port.sv
// Responder for LSB load/store requests: serialises 1/2/4-byte accesses onto a byte-wide RAM bus.
// Optional `MEMCTRL_IO_STALL_EN holds IO-region stores in IO_WAIT while io_buffer_full is set.
module lsb_mem_port #(
   parameter int         ROB_W  = 32,
   parameter logic [1:0] IO_SEL = 2'b11
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             rdy,
   input  logic             lsb_req_flag,
   input  logic [1:0]       lsb_req_width,
   input  logic             lsb_req_type,
   input  logic [31:0]      lsb_req_addr,
   input  logic [31:0]      lsb_req_data,
   input  logic [ROB_W-1:0] lsb_req_rob_id,
   input  logic             jump_wrong_stall,
   input  logic             io_buffer_full,
   output logic             lsb_done_flag,
   output logic             ld_cdb_flag,
   output logic [ROB_W-1:0] ld_cdb_rob_id,
   output logic [31:0]      ld_cdb_val,
   output logic [31:0]      mem_a,
   output logic [7:0]       mem_dout,
   output logic             mem_wr,
   input  logic [7:0]       mem_din
);

`ifdef MEMCTRL_IO_STALL_EN
   localparam logic IO_STALL_EN = 1'b1;
`else
   localparam logic IO_STALL_EN = 1'b0;
`endif

   typedef enum logic [1:0] {IDLE = 2'd0, IO_WAIT = 2'd1, LOAD = 2'd2, STORE = 2'd3} state_t;

   state_t           state_r, state_s;
   logic [31:0]      addr_r, addr_s, data_r, data_s, val_r, val_s;
   logic [2:0]       n_r, n_s, cnt_r, cnt_s, width_n_s;
   logic [ROB_W-1:0] rob_r, rob_s, cdb_rob_s;
   logic             flush_r, flush_s;
   logic             done_s, cdb_s, mem_wr_s;
   logic [31:0]      cdb_val_s, mem_a_s;
   logic [7:0]       mem_dout_s;
   logic             accept_s, io_stall_s, flush_now_s;
   logic [31:0]      data_shift_s, ld_merge_s, next_addr_s;

   // cnt_r counts edges since acceptance; a request seen during a done pulse is a stale repeat
   assign accept_s     = (state_r == IDLE) && lsb_req_flag && !lsb_done_flag;
   assign io_stall_s   = IO_STALL_EN && lsb_req_type && (lsb_req_addr[17:16] == IO_SEL);
   assign flush_now_s  = flush_r | jump_wrong_stall;
   assign data_shift_s = data_r >> {cnt_r, 3'b000};
   assign ld_merge_s   = val_r | ({24'd0, mem_din} << {cnt_r - 3'd2, 3'b000});
   assign next_addr_s  = addr_r + {29'd0, cnt_r};

   // Byte count for the requested width (reserved 10 behaves as word)
   always_comb begin
      case (lsb_req_width)
         2'b00:   width_n_s = 3'd1;
         2'b01:   width_n_s = 3'd2;
         default: width_n_s = 3'd4;
      endcase
   end

   // State register
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_r <= IDLE;
      end else if (rdy) begin
         state_r <= state_s;
      end
   end

   // Next-state logic
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE: begin
            if (!accept_s)          state_s = IDLE;
            else if (!lsb_req_type) state_s = LOAD;
            else if (io_stall_s)    state_s = IO_WAIT;
            else                    state_s = STORE;
         end
         IO_WAIT: begin
            if (!io_buffer_full) state_s = STORE;
            else                 state_s = IO_WAIT;
         end
         LOAD: begin
            if (cnt_r == n_r + 3'd1) state_s = IDLE;
            else                     state_s = LOAD;
         end
         STORE: begin
            if (cnt_r == n_r) state_s = IDLE;
            else              state_s = STORE;
         end
         default: state_s = IDLE;
      endcase
   end

   // Output / datapath next values
   always_comb begin
      addr_s     = addr_r;
      data_s     = data_r;
      n_s        = n_r;
      cnt_s      = cnt_r;
      rob_s      = rob_r;
      flush_s    = flush_r;
      val_s      = val_r;
      done_s     = 1'b0;
      cdb_s      = 1'b0;
      cdb_rob_s  = ld_cdb_rob_id;
      cdb_val_s  = ld_cdb_val;
      mem_a_s    = mem_a;
      mem_dout_s = mem_dout;
      mem_wr_s   = mem_wr;
      case (state_r)
         IDLE: begin
            mem_wr_s = 1'b0;
            if (accept_s) begin
               addr_s  = lsb_req_addr;
               data_s  = lsb_req_data;
               rob_s   = lsb_req_rob_id;
               n_s     = width_n_s;
               cnt_s   = 3'd1;
               flush_s = 1'b0;
               val_s   = 32'd0;
               mem_a_s = lsb_req_addr;
               if (lsb_req_type && !io_stall_s) begin
                  mem_wr_s   = 1'b1;
                  mem_dout_s = lsb_req_data[7:0];
               end else begin
                  mem_wr_s   = 1'b0;
               end
            end else begin
               cnt_s = cnt_r;
            end
         end
         IO_WAIT: begin
            if (!io_buffer_full) begin
               mem_wr_s   = 1'b1;
               mem_dout_s = data_r[7:0];
               cnt_s      = 3'd1;
            end else begin
               mem_wr_s   = 1'b0;
            end
         end
         LOAD: begin
            mem_wr_s = 1'b0;
            flush_s  = flush_now_s;
            cnt_s    = cnt_r + 3'd1;
            if (cnt_r < n_r) mem_a_s = next_addr_s;
            else             mem_a_s = mem_a;
            if (cnt_r >= 3'd2) val_s = ld_merge_s;
            else               val_s = val_r;
            // Last byte arrives on the done edge, so the result merges mem_din directly
            if (cnt_r == n_r + 3'd1) begin
               done_s    = 1'b1;
               cdb_s     = !flush_now_s;
               cdb_rob_s = rob_r;
               cdb_val_s = ld_merge_s;
            end else begin
               done_s    = 1'b0;
            end
         end
         STORE: begin
            cnt_s = cnt_r + 3'd1;
            if (cnt_r < n_r) begin
               mem_a_s    = next_addr_s;
               mem_dout_s = data_shift_s[7:0];
               mem_wr_s   = 1'b1;
            end else begin
               mem_wr_s   = 1'b0;
               done_s     = 1'b1;
            end
         end
         default: mem_wr_s = 1'b0;
      endcase
   end

   // Datapath and output registers
   always_ff @(posedge clk) begin
      if (!rst) begin
         addr_r        <= 32'd0;
         data_r        <= 32'd0;
         val_r         <= 32'd0;
         n_r           <= 3'd0;
         cnt_r         <= 3'd0;
         rob_r         <= '0;
         flush_r       <= 1'b0;
         lsb_done_flag <= 1'b0;
         ld_cdb_flag   <= 1'b0;
         ld_cdb_rob_id <= '0;
         ld_cdb_val    <= 32'd0;
         mem_a         <= 32'd0;
         mem_dout      <= 8'd0;
         mem_wr        <= 1'b0;
      end else if (rdy) begin
         addr_r        <= addr_s;
         data_r        <= data_s;
         val_r         <= val_s;
         n_r           <= n_s;
         cnt_r         <= cnt_s;
         rob_r         <= rob_s;
         flush_r       <= flush_s;
         lsb_done_flag <= done_s;
         ld_cdb_flag   <= cdb_s;
         ld_cdb_rob_id <= cdb_rob_s;
         ld_cdb_val    <= cdb_val_s;
         mem_a         <= mem_a_s;
         mem_dout      <= mem_dout_s;
         mem_wr        <= mem_wr_s;
      end
   end

endmodule

// File: tb/tb_lsb_mem_port.sv
// Directed bench for lsb_mem_port with a byte-wide RAM model (1-cycle read latency, rdy-gated).
module tb_lsb_mem_port;
   logic        clk = 1'b0;
   logic        rst, rdy;
   logic        lsb_req_flag, lsb_req_type;
   logic [1:0]  lsb_req_width;
   logic [31:0] lsb_req_addr, lsb_req_data, lsb_req_rob_id;
   logic        jump_wrong_stall, io_buffer_full;
   logic        lsb_done_flag, ld_cdb_flag, mem_wr;
   logic [31:0] ld_cdb_rob_id, ld_cdb_val, mem_a;
   logic [7:0]  mem_dout;
   logic [7:0]  mem_din = 8'd0;

   int vectors = 0;
   int miscompares = 0;
   int lat, dn;

   logic [7:0]  init_img [0:4095];
   bit   [7:0]  wr_img   [0:4095];
   bit          wr_valid [0:4095];
   logic [31:0] wa_q[$];
   logic [7:0]  wd_q[$];

   always #5 clk = ~clk;

   lsb_mem_port #(.ROB_W(32), .IO_SEL(2'b11)) dut (
      .clk(clk), .rst(rst), .rdy(rdy),
      .lsb_req_flag(lsb_req_flag), .lsb_req_width(lsb_req_width), .lsb_req_type(lsb_req_type),
      .lsb_req_addr(lsb_req_addr), .lsb_req_data(lsb_req_data), .lsb_req_rob_id(lsb_req_rob_id),
      .jump_wrong_stall(jump_wrong_stall), .io_buffer_full(io_buffer_full),
      .lsb_done_flag(lsb_done_flag), .ld_cdb_flag(ld_cdb_flag), .ld_cdb_rob_id(ld_cdb_rob_id),
      .ld_cdb_val(ld_cdb_val), .mem_a(mem_a), .mem_dout(mem_dout), .mem_wr(mem_wr),
      .mem_din(mem_din)
   );

   // RAM model: writes logged, reads return the preload image unless overwritten
   always @(posedge clk) begin
      if (rdy === 1'b1) begin
         if (mem_wr === 1'b1) begin
            wr_img[mem_a[11:0]]   <= mem_dout;
            wr_valid[mem_a[11:0]] <= 1'b1;
            wa_q.push_back(mem_a);
            wd_q.push_back(mem_dout);
         end
         mem_din <= wr_valid[mem_a[11:0]] ? wr_img[mem_a[11:0]] : init_img[mem_a[11:0]];
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // One spacer edge, then present a request for the acceptance edge E0
   task automatic issue(input logic typ, input logic [1:0] w, input logic [31:0] a,
                        input logic [31:0] d, input logic [31:0] rob, input bit hold);
      step();
      wa_q.delete();
      wd_q.delete();
      lsb_req_type   = typ;
      lsb_req_width  = w;
      lsb_req_addr   = a;
      lsb_req_data   = d;
      lsb_req_rob_id = rob;
      lsb_req_flag   = 1'b1;
      step();
      if (!hold) lsb_req_flag = 1'b0;
   endtask

   task automatic wait_done(input int stall_at, output int l);
      l = 0;
      for (int k = 1; k <= 12; k++) begin
         jump_wrong_stall = (k == stall_at);
         step();
         jump_wrong_stall = 1'b0;
         if (lsb_done_flag === 1'b1) begin
            l = k;
            break;
         end
      end
   endtask

   initial begin
      for (int i = 0; i < 4096; i++) init_img[i] = 8'h00;
      init_img[12'h100] = 8'h11; init_img[12'h101] = 8'h22;
      init_img[12'h102] = 8'h33; init_img[12'h103] = 8'h44;
      init_img[12'h104] = 8'h55; init_img[12'h105] = 8'h66;
      init_img[12'h106] = 8'h77; init_img[12'h107] = 8'h88;
      rst = 1'b0; rdy = 1'b1; lsb_req_flag = 1'b0; lsb_req_type = 1'b0;
      lsb_req_width = 2'b00; lsb_req_addr = 32'd0; lsb_req_data = 32'd0; lsb_req_rob_id = 32'd0;
      jump_wrong_stall = 1'b0; io_buffer_full = 1'b0;

      step(); step();
      chk("rst_done", {31'd0, lsb_done_flag}, 32'd0);
      chk("rst_cdb", {31'd0, ld_cdb_flag}, 32'd0);
      chk("rst_wr", {31'd0, mem_wr}, 32'd0);
      chk("rst_a", mem_a, 32'd0);
      chk("rst_dout", {24'd0, mem_dout}, 32'd0);
      chk("rst_val", ld_cdb_val, 32'd0);
      rst = 1'b1;

      // LW @0x100
      issue(1'b0, 2'b11, 32'h100, 32'd0, 32'd7, 1'b0);
      wait_done(0, lat);
      chk("lw_lat", lat, 32'd5);
      chk("lw_cdb", {31'd0, ld_cdb_flag}, 32'd1);
      chk("lw_val", ld_cdb_val, 32'h44332211);
      chk("lw_rob", ld_cdb_rob_id, 32'd7);
      step();
      chk("lw_done_pulse", {31'd0, lsb_done_flag}, 32'd0);
      chk("lw_cdb_pulse", {31'd0, ld_cdb_flag}, 32'd0);

      // LW with misprediction flush at cycle 2
      issue(1'b0, 2'b11, 32'h100, 32'd0, 32'd5, 1'b0);
      wait_done(2, lat);
      chk("fl_lat", lat, 32'd5);
      chk("fl_cdb", {31'd0, ld_cdb_flag}, 32'd0);

      // LBU @0x103 holding 0xF0
      init_img[12'h103] = 8'hF0;
      issue(1'b0, 2'b00, 32'h103, 32'd0, 32'd1, 1'b0);
      wait_done(0, lat);
      chk("lbu_lat", lat, 32'd2);
      chk("lbu_cdb", {31'd0, ld_cdb_flag}, 32'd1);
      chk("lbu_val", ld_cdb_val, 32'h000000F0);

      // SH @0x200
      issue(1'b1, 2'b01, 32'h200, 32'hAABBCCDD, 32'd3, 1'b0);
      wait_done(0, lat);
      chk("sh_lat", lat, 32'd2);
      chk("sh_cdb", {31'd0, ld_cdb_flag}, 32'd0);
      chk("sh_wr_end", {31'd0, mem_wr}, 32'd0);
      chk("sh_nwr", wa_q.size(), 32'd2);
      chk("sh_a0", (wa_q.size() > 0) ? wa_q[0] : 32'hFFFFFFFF, 32'h200);
      chk("sh_d0", (wd_q.size() > 0) ? {24'd0, wd_q[0]} : 32'hFFFFFFFF, 32'hDD);
      chk("sh_a1", (wa_q.size() > 1) ? wa_q[1] : 32'hFFFFFFFF, 32'h201);
      chk("sh_d1", (wd_q.size() > 1) ? {24'd0, wd_q[1]} : 32'hFFFFFFFF, 32'hCC);

      // LW @0x104 with req held high throughout, including the stale done-cycle edge
      issue(1'b0, 2'b11, 32'h104, 32'd0, 32'd9, 1'b1);
      wait_done(0, lat);
      chk("rep_lat", lat, 32'd5);
      chk("rep_val", ld_cdb_val, 32'h88776655);
      chk("rep_rob", ld_cdb_rob_id, 32'd9);
      step();
      chk("rep_pulse", {31'd0, lsb_done_flag}, 32'd0);
      lsb_req_flag = 1'b0;
      dn = 0;
      for (int k = 0; k < 7; k++) begin
         step();
         dn += int'(lsb_done_flag);
      end
      chk("rep_extra_done", dn, 32'd0);

      // SB to the IO region with the IO sink full
      io_buffer_full = 1'b1;
      issue(1'b1, 2'b00, 32'h00030000, 32'h0000005A, 32'd4, 1'b0);
`ifdef MEMCTRL_IO_STALL_EN
      chk("io_hold0", {31'd0, mem_wr}, 32'd0);
      step();
      chk("io_hold1", {31'd0, mem_wr}, 32'd0);
      step();
      chk("io_hold2", {31'd0, mem_wr}, 32'd0);
      io_buffer_full = 1'b0;
      step();
      chk("io_wr", {31'd0, mem_wr}, 32'd1);
      chk("io_a", mem_a, 32'h00030000);
      chk("io_dout", {24'd0, mem_dout}, 32'h5A);
`else
      chk("io_wr", {31'd0, mem_wr}, 32'd1);
      chk("io_dout", {24'd0, mem_dout}, 32'h5A);
`endif
      wait_done(0, lat);
      io_buffer_full = 1'b0;
      chk("io_lat", lat, 32'd1);
      chk("io_nwr", wa_q.size(), 32'd1);

      // SB with rdy low for two cycles mid-access
      issue(1'b1, 2'b00, 32'h400, 32'h00000077, 32'd6, 1'b0);
      rdy = 1'b0;
      step(); step();
      chk("rdy_wr_hold", {31'd0, mem_wr}, 32'd1);
      chk("rdy_done_hold", {31'd0, lsb_done_flag}, 32'd0);
      rdy = 1'b1;
      wait_done(0, lat);
      chk("rdy_lat", lat, 32'd1);
      chk("rdy_nwr", wa_q.size(), 32'd1);

      // Reset while a word store is on byte 2
      issue(1'b1, 2'b11, 32'h300, 32'h04030201, 32'd2, 1'b0);
      step(); step();
      chk("sw_a2", mem_a, 32'h302);
      chk("sw_d2", {24'd0, mem_dout}, 32'h03);
      chk("sw_wr2", {31'd0, mem_wr}, 32'd1);
      rst = 1'b0;
      step();
      rst = 1'b1;
      chk("mrst_wr", {31'd0, mem_wr}, 32'd0);
      chk("mrst_a", mem_a, 32'd0);
      dn = 0;
      for (int k = 0; k < 5; k++) begin
         step();
         dn += int'(lsb_done_flag);
      end
      chk("mrst_done", dn, 32'd0);
      chk("mrst_byte3", {31'd0, wr_valid[12'h303]}, 32'd0);
      issue(1'b0, 2'b00, 32'h100, 32'd0, 32'd8, 1'b0);
      wait_done(0, lat);
      chk("post_lat", lat, 32'd2);
      chk("post_val", ld_cdb_val, 32'h00000011);
      chk("post_rob", ld_cdb_rob_id, 32'd8);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
